// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch buffer: NOP encoding, entry layout and a popcount helper.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int          FETCH_XLEN = 32;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] addr;
    logic [31:0]           instr;
  } fetch_entry_t;

  function automatic int popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n = n + int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/fetch_buffer_lane_compactor.sv
// Squeezes the hit lanes of a fetch group towards lane 0, keeping ascending lane order.
module lane_compactor
  import fetch_pkg::*;
#(
  parameter int WAYS = 2,
  parameter int XLEN = 32
) (
  input  logic [WAYS-1:0]                    hit,
  input  logic [WAYS-1:0][XLEN-1:0]          addresses,
  input  logic [WAYS-1:0][31:0]              instrs,
  output logic [WAYS-1:0][XLEN-1:0]          packed_addresses,
  output logic [WAYS-1:0][31:0]              packed_instrs,
  output logic [$clog2(WAYS+1)-1:0]          n_valid
);

  localparam int NW = $clog2(WAYS + 1);

  always_comb begin
    int slot;
    slot             = 0;
    packed_addresses = '0;
    for (int j = 0; j < WAYS; j++) packed_instrs[j] = NOP_INSTR;
    for (int i = 0; i < WAYS; i++) begin
      if (hit[i]) begin
        for (int j = 0; j < WAYS; j++) begin
          if (j == slot) begin
            packed_addresses[j] = addresses[i];
            packed_instrs[j]    = instrs[i];
          end
        end
        slot = slot + 1;
      end
    end
    n_valid = NW'(popcount(32'(hit)));
  end

endmodule

// File: rtl/fetch_buffer.sv
// WAYS-wide fetch queue: compacts hit lanes into a DEPTH-entry ring and presents the oldest WAYS.
// Optional same-cycle bypass when empty: define FETCH_BUFFER_BYPASS_EN.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int WAYS  = 2,
  parameter int DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [WAYS-1:0][XLEN-1:0]        addresses_in,
  input  logic [WAYS-1:0][31:0]            instrs_in,
  input  logic [WAYS-1:0]                  hit,
  output logic                             in_ready,
  input  logic                             stop,
  output logic [WAYS-1:0][XLEN-1:0]        addresses_out,
  output logic [WAYS-1:0][31:0]            instrs_out,
  output logic [WAYS-1:0]                  out_valid,
  output logic [$clog2(DEPTH):0]           count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = $clog2(WAYS + 1);

  // Handshake: an input group transfers on any cycle with in_ready && |hit && !flush;
  // every out_valid lane transfers on any cycle with !stop.

  logic [PW-1:0]             rd_ptr, wr_ptr;
  logic [XLEN-1:0]           addr_mem  [DEPTH];
  logic [31:0]               instr_mem [DEPTH];
  logic [WAYS-1:0][XLEN-1:0] cmp_addr;
  logic [WAYS-1:0][31:0]     cmp_instr;
  logic [NW-1:0]             n_in;
  logic                      push;
  int                        n_out, n_popped, n_skip, n_pushed;

  lane_compactor #(.WAYS(WAYS), .XLEN(XLEN)) u_compactor (
    .hit              (hit),
    .addresses        (addresses_in),
    .instrs           (instrs_in),
    .packed_addresses (cmp_addr),
    .packed_instrs    (cmp_instr),
    .n_valid          (n_in)
  );

  assign in_ready = (DEPTH - int'(count)) >= WAYS;
  assign push     = in_ready && (|hit) && !flush;

  always_comb begin
    n_out         = (int'(count) < WAYS) ? int'(count) : WAYS;
    out_valid     = '0;
    addresses_out = '0;
    for (int i = 0; i < WAYS; i++) instrs_out[i] = NOP_INSTR;
    for (int i = 0; i < WAYS; i++) begin
      if (i < n_out) begin
        out_valid[i]     = 1'b1;
        addresses_out[i] = addr_mem[rd_ptr + PW'(i)];
        instrs_out[i]    = instr_mem[rd_ptr + PW'(i)];
      end
    end
    n_popped = stop ? 0 : n_out;
    n_skip   = 0;
`ifdef FETCH_BUFFER_BYPASS_EN
    // Empty queue: incoming lanes go straight out; consumed lanes are never written.
    if (count == '0 && push) begin
      for (int i = 0; i < WAYS; i++) begin
        if (i < int'(n_in)) begin
          out_valid[i]     = 1'b1;
          addresses_out[i] = cmp_addr[i];
          instrs_out[i]    = cmp_instr[i];
        end
      end
      n_popped = 0;
      n_skip   = stop ? 0 : popcount(32'(out_valid));
    end
`endif
    n_pushed = push ? (int'(n_in) - n_skip) : 0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        addr_mem[e]  <= '0;
        instr_mem[e] <= NOP_INSTR;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      for (int j = 0; j < WAYS; j++) begin
        if (push && j >= n_skip && j < int'(n_in)) begin
          addr_mem[wr_ptr + PW'(j - n_skip)]  <= cmp_addr[j];
          instr_mem[wr_ptr + PW'(j - n_skip)] <= cmp_instr[j];
        end
      end
      wr_ptr <= wr_ptr + PW'(n_pushed);
      rd_ptr <= rd_ptr + PW'(n_popped);
      count  <= CW'(int'(count) + n_pushed - n_popped);
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer (WAYS=2, DEPTH=8) with an address-order scoreboard.
module tb_fetch_buffer;

  localparam int XLEN  = 32;
  localparam int WAYS  = 2;
  localparam int DEPTH = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic                      clk;
  logic                      reset;
  logic                      flush;
  logic [WAYS-1:0][XLEN-1:0] addresses_in;
  logic [WAYS-1:0][31:0]     instrs_in;
  logic [WAYS-1:0]           hit;
  logic                      in_ready;
  logic                      stop;
  logic [WAYS-1:0][XLEN-1:0] addresses_out;
  logic [WAYS-1:0][31:0]     instrs_out;
  logic [WAYS-1:0]           out_valid;
  logic [3:0]                count;

  int checks = 0;
  int fails  = 0;
  logic [XLEN-1:0] exp_q[$];

  fetch_buffer #(.XLEN(XLEN), .WAYS(WAYS), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .addresses_in  (addresses_in),
    .instrs_in     (instrs_in),
    .hit           (hit),
    .in_ready      (in_ready),
    .stop          (stop),
    .addresses_out (addresses_out),
    .instrs_out    (instrs_out),
    .out_valid     (out_valid),
    .count         (count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [XLEN-1:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // driver
  task automatic drive_group(input logic [1:0] h, input logic [XLEN-1:0] a0, input logic [XLEN-1:0] a1);
    hit             = h;
    addresses_in[0] = a0;
    addresses_in[1] = a1;
    instrs_in[0]    = instr_of(a0);
    instrs_in[1]    = instr_of(a1);
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    hit  = '0;
    stop = 1'b0;
    while (count != 0 && n < 20) begin
      tick;
      n++;
    end
    checks++;
    if (count !== 4'd0) begin
      fails++;
      $display("FAIL %s_drain: count=%0d required 0 within 20 cycles", name, count);
    end
  endtask

  // scoreboard: every lane leaving the buffer must be the next expected address
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (count > DEPTH) begin
        fails++;
        $display("FAIL count_bound: count=%0d required <= %0d", count, DEPTH);
      end
      if (!flush && !stop) begin
        for (int i = 0; i < WAYS; i++) begin
          if (out_valid[i] === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
              fails++;
              $display("FAIL sb_order: lane%0d addr=%0h appeared with nothing expected", i, addresses_out[i]);
            end else begin
              logic [XLEN-1:0] e;
              e = exp_q.pop_front();
              if (addresses_out[i] !== e) begin
                fails++;
                $display("FAIL sb_order: lane%0d addr=%0h required %0h", i, addresses_out[i], e);
              end
            end
          end
        end
      end
    end
  end

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) tick;
    checks++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d required 0", count); end
    checks++; if (out_valid !== 2'b00) begin fails++; $display("FAIL reset_valid: got %b required 00", out_valid); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b required 1", in_ready); end
    checks++; if (instrs_out[0] !== NOP) begin fails++; $display("FAIL reset_instr: got %h required %h", instrs_out[0], NOP); end
    checks++; if (addresses_out[1] !== '0) begin fails++; $display("FAIL reset_addr: got %h required 0", addresses_out[1]); end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_two_wide;
    stop = 1'b0;
    drive_group(2'b11, 32'h100, 32'h104);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    #1;
`ifdef FETCH_BUFFER_BYPASS_EN
    checks++; if (out_valid !== 2'b11) begin fails++; $display("FAIL bypass_valid: got %b required 11", out_valid); end
    checks++; if (addresses_out[1] !== 32'h104) begin fails++; $display("FAIL bypass_addr1: got %h required 104", addresses_out[1]); end
    tick;
    hit = '0;
    #1;
    checks++; if (count !== 4'd0) begin fails++; $display("FAIL bypass_count: got %0d required 0", count); end
`else
    checks++; if (out_valid !== 2'b00) begin fails++; $display("FAIL two_wide_latency: got %b required 00", out_valid); end
    tick;
    hit = '0;
    #1;
    checks++; if (out_valid !== 2'b11) begin fails++; $display("FAIL two_wide_valid: got %b required 11", out_valid); end
    checks++; if (addresses_out[0] !== 32'h100) begin fails++; $display("FAIL two_wide_addr0: got %h required 100", addresses_out[0]); end
    checks++; if (addresses_out[1] !== 32'h104) begin fails++; $display("FAIL two_wide_addr1: got %h required 104", addresses_out[1]); end
    checks++; if (instrs_out[1] !== instr_of(32'h104)) begin fails++; $display("FAIL two_wide_instr1: got %h required %h", instrs_out[1], instr_of(32'h104)); end
    checks++; if (count !== 4'd2) begin fails++; $display("FAIL two_wide_count: got %0d required 2", count); end
    tick;
`endif
    checks++; if (out_valid !== 2'b00) begin fails++; $display("FAIL two_wide_drained: got %b required 00", out_valid); end
    checks++; if (count !== 4'd0) begin fails++; $display("FAIL two_wide_empty: got %0d required 0", count); end
  endtask

  task automatic test_partial_hit;
    stop = 1'b0;
    drive_group(2'b10, 32'h200, 32'h204);
    exp_q.push_back(32'h204);
    #1;
`ifndef FETCH_BUFFER_BYPASS_EN
    checks++; if (out_valid !== 2'b00) begin fails++; $display("FAIL partial_latency: got %b required 00", out_valid); end
    tick;
    hit = '0;
    #1;
    checks++; if (count !== 4'd1) begin fails++; $display("FAIL partial_count: got %0d required 1", count); end
    checks++; if (addresses_out[1] !== '0) begin fails++; $display("FAIL partial_addr1: got %h required 0", addresses_out[1]); end
`endif
    checks++; if (out_valid !== 2'b01) begin fails++; $display("FAIL partial_valid: got %b required 01", out_valid); end
    checks++; if (addresses_out[0] !== 32'h204) begin fails++; $display("FAIL partial_addr0: got %h required 204", addresses_out[0]); end
    checks++; if (instrs_out[0] !== instr_of(32'h204)) begin fails++; $display("FAIL partial_instr0: got %h required %h", instrs_out[0], instr_of(32'h204)); end
    checks++; if (instrs_out[1] !== NOP) begin fails++; $display("FAIL partial_nop: got %h required %h", instrs_out[1], NOP); end
    tick;
    hit = '0;
    #1;
    checks++; if (count !== 4'd0) begin fails++; $display("FAIL partial_empty: got %0d required 0", count); end
  endtask

  task automatic test_full_stop;
    logic [3:0] exp_cnt;
    stop = 1'b1;
    for (int g = 0; g < 4; g++) begin
      drive_group((g == 3) ? 2'b01 : 2'b11, 32'h300 + 32'(16 * g), 32'h304 + 32'(16 * g));
      exp_q.push_back(32'h300 + 32'(16 * g));
      if (g != 3) exp_q.push_back(32'h304 + 32'(16 * g));
      #1;
      checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL fill_ready%0d: got %b required 1", g, in_ready); end
      tick;
      exp_cnt = (g == 3) ? 4'd7 : 4'(2 * (g + 1));
      checks++; if (count !== exp_cnt) begin fails++; $display("FAIL fill_count%0d: got %0d required %0d", g, count, exp_cnt); end
    end
    drive_group(2'b11, 32'h340, 32'h344);
    #1;
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %b required 0", in_ready); end
    tick;
    checks++; if (count !== 4'd7) begin fails++; $display("FAIL full_hold: got %0d required 7", count); end
    stop = 1'b0;
    tick;
    checks++; if (count !== 4'd5) begin fails++; $display("FAIL full_pop: got %0d required 5", count); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_reopen: got %b required 1", in_ready); end
    exp_q.push_back(32'h340);
    exp_q.push_back(32'h344);
    tick;
    checks++; if (count !== 4'd5) begin fails++; $display("FAIL full_accept: got %0d required 5", count); end
    wait_empty("full");
  endtask

  task automatic test_push_pop_wrap;
    stop = 1'b1;
    for (int k = 0; k < 16; k += 2) begin
      if (k == 4) stop = 1'b0;
      drive_group(2'b11, 32'h400 + 32'(4 * k), 32'h404 + 32'(4 * k));
      exp_q.push_back(32'h400 + 32'(4 * k));
      exp_q.push_back(32'h404 + 32'(4 * k));
      tick;
      if (k >= 2) begin
        checks++; if (count !== 4'd4) begin fails++; $display("FAIL push_pop_count%0d: got %0d required 4", k, count); end
      end
    end
    wait_empty("push_pop");
  endtask

  task automatic test_flush;
    stop = 1'b1;
    drive_group(2'b11, 32'hB00, 32'hB04);
    tick;
    drive_group(2'b11, 32'hB10, 32'hB14);
    tick;
    drive_group(2'b01, 32'hB20, 32'hB24);
    tick;
    checks++; if (count !== 4'd5) begin fails++; $display("FAIL flush_setup: got %0d required 5", count); end
    flush = 1'b1;
    stop  = 1'b0;
    drive_group(2'b11, 32'hBF0, 32'hBF4);
    tick;
    flush = 1'b0;
    hit   = '0;
    #1;
    checks++; if (count !== 4'd0) begin fails++; $display("FAIL flush_count: got %0d required 0", count); end
    checks++; if (out_valid !== 2'b00) begin fails++; $display("FAIL flush_valid: got %b required 00", out_valid); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_ready: got %b required 1", in_ready); end
    repeat (3) tick;
    drive_group(2'b11, 32'h600, 32'h604);
    exp_q.push_back(32'h600);
    exp_q.push_back(32'h604);
    tick;
    wait_empty("flush");
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    stop  = 1'b0;
    hit   = '0;
    addresses_in = '0;
    instrs_in    = '0;
    test_reset;
    test_two_wide;
    test_partial_hit;
    test_full_stop;
    test_push_pop_wrap;
    test_flush;
    repeat (2) tick;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: %0d expected addresses never appeared, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
